// File: rtl/ramp_controller.sv
// ramp_controller: multi-channel ramp generator.
// Each channel ramps a scale factor from 0 up to full scale, holds it, and
// ramps it back to 0 when asked, all paced by one shared tick divider.

module ramp_controller #(
    parameter int CHANNELS   = 2,
    parameter int RAMP_WIDTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           run,
    input  logic [CHANNELS-1:0]            enable_ramping,
    input  logic [CHANNELS-1:0]            start_ramp_down,
    input  logic [CHANNELS*RAMP_WIDTH-1:0] ramp_step,
    input  logic [DIV_WIDTH-1:0]           divider,
    output logic [CHANNELS*RAMP_WIDTH-1:0] ramp_factor,
    output logic [CHANNELS*3-1:0]          ramp_state,
    output logic [CHANNELS-1:0]            ramp_done,
    output logic                           all_done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP   = 3'd1,
        HOLD = 3'd2,
        DOWN = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [RAMP_WIDTH-1:0] FULL     = '1;
    localparam logic [DIV_WIDTH-1:0]  CNT_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [CHANNELS-1:0]  active;
    logic [CHANNELS-1:0]  done_d;
    logic                 any_active;
    logic                 tick;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic                 all_done_q;

    // The divider only runs while some channel is actually ramping or holding.
    assign any_active = |active;
    assign tick       = any_active && (cnt_q == divider);

    // Shared tick counter: wraps at the divider value, parked at 0 when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!any_active || (cnt_q >= divider)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    // All channels done together, registered so it lines up with ramp_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_done_q <= 1'b0;
        end else begin
            all_done_q <= &done_d;
        end
    end

    assign all_done = all_done_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [2:0]            state_q, state_d;
        logic [RAMP_WIDTH-1:0] factor_q, factor_d;
        logic                  ramp_q, ramp_d;
        logic                  done_q;
        logic [RAMP_WIDTH-1:0] step_raw;
        logic [RAMP_WIDTH-1:0] step_eff;
        logic [RAMP_WIDTH:0]   sum_w;
        logic                  stop;

        // A zero step means "jump the whole way on the next tick".
        assign step_raw = ramp_step[i*RAMP_WIDTH +: RAMP_WIDTH];
        assign step_eff = (step_raw == '0) ? FULL : step_raw;
        assign sum_w    = {1'b0, factor_q} + {1'b0, step_eff};
        assign stop     = start_ramp_down[i] | ~run;

        assign active[i] = (state_q == UP) || (state_q == HOLD) || (state_q == DOWN);
        assign done_d[i] = (state_d == DONE);

        // Next-state and next-factor decision for this channel.
        always_comb begin
            state_d  = state_q;
            factor_d = factor_q;
            ramp_d   = ramp_q;
            case (state_q)
                IDLE: begin
                    factor_d = '0;
                    if (run) begin
                        ramp_d = enable_ramping[i];
                        if (enable_ramping[i]) begin
                            state_d = UP;
                        end else begin
                            state_d  = HOLD;
                            factor_d = FULL;
                        end
                    end
                end
                UP: begin
                    if (stop) begin
                        if (ramp_q) begin
                            state_d = DOWN;
                        end else begin
                            state_d  = DONE;
                            factor_d = '0;
                        end
                    end else if (tick) begin
                        if (sum_w >= {1'b0, FULL}) begin
                            factor_d = FULL;
                            state_d  = HOLD;
                        end else begin
                            factor_d = sum_w[RAMP_WIDTH-1:0];
                        end
                    end
                end
                HOLD: begin
                    factor_d = FULL;
                    if (stop) begin
                        if (ramp_q) begin
                            state_d = DOWN;
                        end else begin
                            state_d  = DONE;
                            factor_d = '0;
                        end
                    end
                end
                DOWN: begin
                    if (tick) begin
                        if (factor_q <= step_eff) begin
                            factor_d = '0;
                            state_d  = DONE;
                        end else begin
                            factor_d = factor_q - step_eff;
                        end
                    end
                end
                DONE: begin
                    factor_d = '0;
                    if (!run && !start_ramp_down[i]) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    factor_d = '0;
                end
            endcase
        end

        // Channel registers; reset aborts straight to IDLE with no ramp-down.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q  <= IDLE;
                factor_q <= '0;
                ramp_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                factor_q <= factor_d;
                ramp_q   <= ramp_d;
                done_q   <= done_d[i];
            end
        end

        assign ramp_factor[i*RAMP_WIDTH +: RAMP_WIDTH] = factor_q;
        assign ramp_state[i*3 +: 3]                    = state_q;
        assign ramp_done[i]                            = done_q;
    end

endmodule

// File: doc/ramp_controller.md
RAMP_CONTROLLER -- requirements
Module: ramp_controller

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent ramp channels.
REQ-002 SHALL have parameter RAMP_WIDTH, default 16: width of each ramp factor and step; FULL = 2^RAMP_WIDTH-1.
REQ-003 SHALL have parameter DIV_WIDTH, default 16: width of the shared tick divider.
REQ-004 SHALL have port clk  in  1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous and active-high.
REQ-006 SHALL have port run  in  1: global run level; rising level starts, falling level requests ramp-down.
REQ-007 SHALL have port enable_ramping  in  CHANNELS: per-channel ramp enable, latched on leaving IDLE.
REQ-008 SHALL have port start_ramp_down  in  CHANNELS: per-channel ramp-down request, level-sensitive.
REQ-009 SHALL have port ramp_step  in  CHANNELS*RAMP_WIDTH: per-channel step, channel i at bits [i*RAMP_WIDTH +: RAMP_WIDTH], sampled live.
REQ-010 SHALL have port divider  in  DIV_WIDTH: tick period minus one, sampled live.
REQ-011 SHALL have port ramp_factor  out  CHANNELS*RAMP_WIDTH: per-channel registered scale factor, same packing as ramp_step.
REQ-012 SHALL have port ramp_state  out  CHANNELS*3: per-channel state code, channel i at [i*3 +: 3].
REQ-013 SHALL have port ramp_done  out  CHANNELS: per-channel, high while the channel is in DONE.
REQ-014 SHALL have port all_done  out  1: AND of ramp_done.

Function
REQ-015 SHALL run per channel an FSM with codes IDLE=0, UP=1, HOLD=2, DOWN=3, DONE=4; codes 5-7 unreachable, and if entered SHALL return to IDLE next cycle.
REQ-016 SHALL generate a shared tick: counter counts 0..divider, tick high for one cycle when counter equals divider; divider=0 gives tick every cycle.
REQ-017 SHALL hold the tick counter at 0 while every channel is in IDLE or DONE.
REQ-018 IDLE: factor 0; when run=1, latch enable_ramping[i] and go to UP if latched 1, else to HOLD with factor FULL, both on the next edge.
REQ-019 UP: on each tick, factor <= min(factor+step, FULL) computed at RAMP_WIDTH+1 bits; go to HOLD on the tick the sum reaches or exceeds FULL.
REQ-020 HOLD: factor held at FULL.
REQ-021 From UP or HOLD, start_ramp_down[i]=1 or run=0 SHALL move the channel to DOWN (ramping latched 1) or DONE with factor 0 (ramping latched 0) on the next edge; in UP this takes priority over the tick.
REQ-022 DOWN: on each tick, factor <= max(factor-step, 0); go to DONE on the tick the result is 0; DOWN starts from the current factor, so an interrupted UP reverses without a jump.
REQ-023 A step of 0 SHALL be treated as FULL, so the ramp completes on the next tick.
REQ-024 DONE: factor 0; stay until run=0 and start_ramp_down[i]=0, then go to IDLE.
REQ-025 Re-asserting run or changing enable_ramping during DOWN or DONE SHALL have no effect until the channel reaches IDLE.
REQ-026 Channels SHALL share only the tick and run; each SHALL otherwise be fully independent.
REQ-027 All outputs SHALL be registered; state change and factor update are visible one cycle after the causing edge.

Reset
REQ-028 While rst=1, all channels SHALL be in IDLE, ramp_factor=0, ramp_state=0, ramp_done=0, all_done=0 and the tick counter 0, regardless of clk.
REQ-029 After rst deasserts with run=1, channels SHALL leave IDLE on the first clk edge.
REQ-030 rst asserted mid-ramp SHALL abort immediately to IDLE with factor 0, with no ramp-down.

Verification
REQ-031 Setup CHANNELS=2, RAMP_WIDTH=16, divider=0, step0=0x4000, enable=2'b01, run 0->1: ch0 factor 0x4000, 0x8000, 0xC000, 0xFFFF then HOLD; ch1 factor 0xFFFF in HOLD one cycle after leaving IDLE.
REQ-032 divider=3, step=0x8000, ramping on: factor changes every 4th cycle: 0x8000, then 0xFFFF/HOLD; counter held at 0 before run.
REQ-033 Ch0 at 0xC000 in UP, start_ramp_down[0] pulsed 1 cycle: DOWN to 0x8000, 0x4000, 0x0000, then DONE; ramp_done[0]=1; no return to IDLE until run=0.
REQ-034 step=0, ramping on: UP to 0xFFFF in one tick; after run=0, DOWN to 0 in one tick; all_done=1 once both channels are in DONE.
REQ-035 rst pulsed while ch0 is in DOWN at 0x8000: all outputs 0 asynchronously; with run held 1, ch0 restarts UP from 0.
REQ-036 Write to state code 6 via force: channel returns to IDLE next cycle with factor 0.
